// File: rtl/cordic_sched.sv
// ---------------------------------------------------------------------------
// cordic_sched
//   Round-robin front end that shares one multi-cycle CORDIC core between two
//   angle requesters. A request is accepted over valid/ready, issued to the
//   core with a one-cycle start pulse, and the core's sin/cos are captured on
//   done and returned, tagged with the requester id, over a valid/ready
//   response channel. Exactly one transaction is in flight at a time.
//
// Configuration macro:
//   CORDIC_SCHED_TIMEOUT_EN  - when defined, WAIT aborts after TIMEOUT_CYC
//                              cycles without core_done and returns
//                              sin=cos=0 with rsp_err=1. When undefined, WAIT
//                              waits indefinitely and rsp_err is tied to 0.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   req0_valid/beta/ready        requester 0 angle handshake
//   req1_valid/beta/ready        requester 1 angle handshake
//   core_start, core_beta        start pulse and angle to the core
//   core_done, core_sin/cos      core result strobe and data
//   rsp_valid/id/sin/cos/err     response to the owning requester
//   rsp_ready                    response consumer accept
//   busy                         a transaction is in flight
// ---------------------------------------------------------------------------
module cordic_sched #(
    parameter int W           = 17,
    parameter int ITER        = 9,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_beta,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_beta,
    output logic         req1_ready,
    output logic         core_start,
    output logic [W-1:0] core_beta,
    input  logic         core_done,
    input  logic [W-1:0] core_sin,
    input  logic [W-1:0] core_cos,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sin,
    output logic [W-1:0] rsp_cos,
    output logic         rsp_err,
    input  logic         rsp_ready,
    output logic         busy
);

    // The abort window must leave room for a core that runs its full ITER.
    if (TIMEOUT_CYC <= ITER + 2) begin : g_bad_timeout
        $error("cordic_sched: TIMEOUT_CYC must exceed ITER+2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           id_q, id_d;
    logic [W-1:0]   beta_q, beta_d;
    logic [W-1:0]   sin_q, sin_d;
    logic [W-1:0]   cos_q, cos_d;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]  timer_q, timer_d;
    logic           err_q, err_d;
`endif

    // ---------------------------------------------------------------------
    // Round-robin grant. With both valid, the requester that did not win
    // last time is chosen; a lone valid requester always wins.
    // ---------------------------------------------------------------------
    logic grant_valid;
    logic grant_id;

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is only offered in IDLE and is held low while reset is asserted,
    // so no handshake can appear to complete during reset.
    logic offer;
    assign offer      = rst_n && (state_q == S_IDLE) && grant_valid;
    assign req0_ready = offer && (grant_id == 1'b0);
    assign req1_ready = offer && (grant_id == 1'b1);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch below
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        beta_d       = beta_q;
        sin_d        = sin_q;
        cos_d        = cos_q;
`ifdef CORDIC_SCHED_TIMEOUT_EN
        timer_d      = timer_q;
        err_d        = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                // grant_valid implies the granted requester's valid is high,
                // so an offered ready is always a completed handshake.
                if (grant_valid) begin
                    beta_d       = grant_id ? req1_beta : req0_beta;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
`ifdef CORDIC_SCHED_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // core_done is tested first so a result arriving on the
                // expiry cycle beats the abort.
                if (core_done) begin
                    sin_d   = core_sin;
                    cos_d   = core_cos;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef CORDIC_SCHED_TIMEOUT_EN
                else if (timer_q == TIMER_LAST) begin
                    sin_d   = '0;
                    cos_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers (synchronous reset)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            beta_q       <= '0;
            sin_q        <= '0;
            cos_q        <= '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            timer_q      <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            beta_q       <= beta_d;
            sin_q        <= sin_d;
            cos_q        <= cos_d;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            timer_q      <= timer_d;
            err_q        <= err_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign core_start = (state_q == S_ISSUE);
    assign core_beta  = beta_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_sin    = sin_q;
    assign rsp_cos    = cos_q;
    assign busy       = (state_q != S_IDLE);

`ifdef CORDIC_SCHED_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_sched.sv
// ---------------------------------------------------------------------------
// tb_cordic_sched
//   Directed bench for cordic_sched. A small core model answers each
//   core_start with core_done DLY cycles later, returning sin/cos taken from
//   the current test vector. Transactions come from a vector table; reset,
//   backpressure, mid-transaction reset and (with the macro) timeout are
//   hand-written sequences. Stimulus changes and sampling happen just after
//   the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_cordic_sched;

    localparam int W   = 17;
    localparam int DLY = 9;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_beta, req1_beta;
    logic         req0_ready, req1_ready;
    logic         core_start;
    logic [W-1:0] core_beta;
    logic         core_done;
    logic [W-1:0] core_sin, core_cos;
    logic         rsp_valid, rsp_id, rsp_err, rsp_ready, busy;
    logic [W-1:0] rsp_sin, rsp_cos;

    // core model state
    int           model_dly;
    int           model_cnt;
    logic         model_done;
    logic         man_done;
    logic [W-1:0] model_sin, model_cos;

    int n_tests;
    int n_fail;

    assign core_done = model_done | man_done;
    assign core_sin  = model_sin;
    assign core_cos  = model_cos;

    cordic_sched #(.W(W), .ITER(9), .TIMEOUT_CYC(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_beta  (req0_beta),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_beta  (req1_beta),
        .req1_ready (req1_ready),
        .core_start (core_start),
        .core_beta  (core_beta),
        .core_done  (core_done),
        .core_sin   (core_sin),
        .core_cos   (core_cos),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_sin    (rsp_sin),
        .rsp_cos    (rsp_cos),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: done pulses during the DLY-th cycle after the start cycle.
    // model_dly == 0 models a core that never answers.
    initial begin
        model_cnt  = 0;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                model_cnt  = model_dly;
                model_done = 1'b0;
            end else if (model_cnt > 0) begin
                model_cnt  = model_cnt - 1;
                model_done = (model_cnt == 0);
            end else begin
                model_done = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic         v0;
        logic [W-1:0] b0;
        logic         v1;
        logic [W-1:0] b1;
        logic [W-1:0] sin;
        logic [W-1:0] cos;
        logic         exp_id;
        logic [W-1:0] exp_beta;
    } vec_t;

    vec_t vecs[8];

    // One full transaction: grant check, start pulse, core latency, response
    // contents, response handshake.
    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        req0_valid = v.v0;
        req0_beta  = v.b0;
        req1_valid = v.v1;
        req1_beta  = v.b1;
        model_sin  = v.sin;
        model_cos  = v.cos;
        #1;
        check({tag, ".ready0"}, 64'(req0_ready), 64'(v.exp_id == 1'b0));
        check({tag, ".ready1"}, 64'(req1_ready), 64'(v.exp_id == 1'b1));
        check({tag, ".idle"},   64'(busy), 64'd0);
        tick();
        check({tag, ".start"},  64'(core_start), 64'd1);
        check({tag, ".beta"},   64'(core_beta), 64'(v.exp_beta));
        lat = 0;
        while (!rsp_valid && lat < 60) begin
            tick();
            lat++;
            if (lat == 1) check({tag, ".start_pulse"}, 64'(core_start), 64'd0);
        end
        check({tag, ".rsp_lat"}, 64'(lat), 64'(DLY + 1));
        check({tag, ".rsp"}, {rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err, req0_ready, req1_ready},
              {1'b1, v.exp_id, v.sin, v.cos, 1'b0, 1'b0, 1'b0});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, ".rsp_done"}, 64'({rsp_valid, busy}), 64'd0);
    endtask

    initial begin
        vec_t vx;
        bit   seen;
        int   lat;
        n_tests    = 0;
        n_fail     = 0;
        model_dly  = DLY;
        man_done   = 1'b0;
        model_sin  = '0;
        model_cos  = '0;
        rsp_ready  = 1'b0;
        req1_valid = 1'b0;
        req1_beta  = '0;
        req0_valid = 1'b1;
        req0_beta  = 17'h0C910;
        rst_n      = 1'b0;

        //           v0    b0         v1    b1         sin        cos        id    beta
        vecs[0] = '{1'b1, 17'h0C910, 1'b0, 17'h00000, 17'h05A82, 17'h05A82, 1'b0, 17'h0C910};
        vecs[1] = '{1'b0, 17'h00000, 1'b1, 17'h1F000, 17'h1FFFF, 17'h00000, 1'b1, 17'h1F000};
        vecs[2] = '{1'b1, 17'h00001, 1'b1, 17'h10000, 17'h00001, 17'h1FFFE, 1'b0, 17'h00001};
        vecs[3] = '{1'b1, 17'h0AAAA, 1'b1, 17'h15555, 17'h15555, 17'h0AAAA, 1'b1, 17'h15555};
        vecs[4] = '{1'b1, 17'h00002, 1'b1, 17'h00003, 17'h00002, 17'h1FFFD, 1'b0, 17'h00002};
        vecs[5] = '{1'b1, 17'h00004, 1'b1, 17'h00005, 17'h00005, 17'h1FFFA, 1'b1, 17'h00005};
        vecs[6] = '{1'b1, 17'h1FFFF, 1'b1, 17'h10001, 17'h1FFFF, 17'h00000, 1'b0, 17'h1FFFF};
        vecs[7] = '{1'b1, 17'h07FFF, 1'b1, 17'h18000, 17'h18000, 17'h07FFF, 1'b1, 17'h18000};

        // ---- reset held 3 cycles with req0 valid
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs",
                  {core_start, core_beta, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err, busy,
                   req0_ready, req1_ready}, 64'd0);
        end
        rst_n = 1'b1;
        #1;
        check("post_reset_ready0", 64'(req0_ready), 64'd1);

        // ---- single requests and contention from the table
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- response backpressure with a stray core_done in RESP
        req0_valid = 1'b1;
        req0_beta  = 17'h01234;
        req1_valid = 1'b1;
        req1_beta  = 17'h05678;
        model_sin  = 17'h00AAA;
        model_cos  = 17'h1F555;
        tick();
        check("bp.start", 64'(core_start), 64'd1);
        lat = 0;
        while (!rsp_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("bp.rsp_lat", 64'(lat), 64'(DLY + 1));
        model_sin = 17'h13579;
        model_cos = 17'h02468;
        for (int i = 0; i < 10; i++) begin
            check("bp.hold", {rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err, req0_ready, req1_ready},
                  {1'b1, 1'b0, 17'h00AAA, 17'h1F555, 1'b0, 1'b0, 1'b0});
            man_done = (i == 3);
            tick();
        end
        man_done = 1'b0;
        check("bp.hold_end", {rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err},
              {1'b1, 1'b0, 17'h00AAA, 17'h1F555, 1'b0});
        rsp_ready = 1'b1;
        tick();
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("bp.rsp_done", 64'({rsp_valid, busy}), 64'd0);

        // ---- reset during WAIT; the core's done arrives after release
        req0_valid = 1'b1;
        req0_beta  = 17'h1ABCD;
        #1;
        check("mid.ready0", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        check("mid.start", 64'(core_start), 64'd1);
        tick();
        tick();
        check("mid.wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid.reset_idle", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid || busy) seen = 1'b1;
        end
        check("mid.no_rsp", 64'(seen), 64'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mid.last_grant", 64'({req0_ready, req1_ready}), 64'b10);
        vx = '{1'b1, 17'h00100, 1'b1, 17'h00200, 17'h00300, 17'h00400, 1'b0, 17'h00100};
        run_txn(vx, "mid.next");
        req0_valid = 1'b0;
        req1_valid = 1'b0;

`ifdef CORDIC_SCHED_TIMEOUT_EN
        // ---- core never answers; abort after 32 WAIT cycles
        model_dly  = 0;
        model_sin  = 17'h11111;
        model_cos  = 17'h02222;
        req0_valid = 1'b1;
        req0_beta  = 17'h00777;
        tick();
        req0_valid = 1'b0;
        check("to.start", 64'(core_start), 64'd1);
        lat = 0;
        while (!rsp_valid && lat < 80) begin
            tick();
            lat++;
        end
        check("to.rsp_lat", 64'(lat), 64'd33);
        check("to.rsp", {rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err},
              {1'b1, 1'b0, 17'h00000, 17'h00000, 1'b1});
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check("to.late_done", {rsp_valid, rsp_sin, rsp_cos, rsp_err},
              {1'b1, 17'h00000, 17'h00000, 1'b1});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        man_done  = 1'b1;
        tick();
        man_done  = 1'b0;
        tick();
        check("to.idle_done", 64'({rsp_valid, busy}), 64'd0);
        model_dly = DLY;
        vx = '{1'b0, 17'h00000, 1'b1, 17'h00ABC, 17'h00DEF, 17'h01234, 1'b1, 17'h00ABC};
        run_txn(vx, "to.next");
        req1_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Round-robin scheduler that shares one multi-cycle CORDIC core between two angle requesters.
- Accepts a beta angle from a requester over a valid/ready handshake, then issues it to the core with a one-cycle start pulse.
- Captures the core's sin/cos on done and returns them tagged with the requester ID over a valid/ready response channel.
- Sits between the requester logic and the cordic datapath; one transaction is in flight at a time.

Parameters:
- W, 17, angle/result width (signed fixed point, matches cordic beta/sin/cos).
- ITER, 9, core iteration count; informational, and it sets the timeout floor.
- TIMEOUT_CYC, 32, WAIT-state cycle limit before abort (only used with the macro); must be greater than ITER+2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an angle.
- req0_beta  in  W  requester 0 angle.
- req0_ready  out  1  requester 0 handshake accept.
- req1_valid  in  1  requester 1 has an angle.
- req1_beta  in  W  requester 1 angle.
- req1_ready  out  1  requester 1 handshake accept.
- core_start  out  1  one-cycle start pulse to the core.
- core_beta  out  W  angle to the core; stable from ISSUE until the return to IDLE.
- core_done  in  1  core result valid, single-cycle pulse.
- core_sin  in  W  core sine result.
- core_cos  in  W  core cosine result.
- rsp_valid  out  1  response available.
- rsp_id  out  1  requester that owns the response.
- rsp_sin  out  W  captured sine.
- rsp_cos  out  W  captured cosine.
- rsp_err  out  1  response was aborted (timeout).
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset:
  - Synchronous, active-low on rst_n, sampled at posedge clk.
  - Forces state=IDLE, last_grant=1 (so req0 wins the first tie).
  - All outputs 0 after reset: core_start, core_beta, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err, busy, req*_ready.
  - Reset mid-transaction drops the transaction silently; any later core_done is ignored while in IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is combinational.
    - Only one valid: grant that requester.
    - Both valid: grant !last_grant.
    - Neither valid: no grant.
  - reqX_ready=1 only for the granted requester, and only in IDLE. A ready never depends on the same requester's valid except through grant.
  - On handshake (valid&ready): latch beta into core_beta, latch id, set last_grant=id, go to ISSUE.
- ISSUE:
  - core_start=1 for exactly this cycle; next state WAIT.
  - Clear the timeout counter.
- WAIT:
  - core_start=0.
  - On core_done=1: register core_sin/core_cos into rsp_sin/rsp_cos, set rsp_err=0, go to RESP.
  - core_done outside WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id/sin/cos/err are held stable.
  - On rsp_ready=1: go to IDLE with rsp_valid=0 next cycle.
  - rsp_ready while rsp_valid=0 has no effect.
- Latency:
  - Request handshake at cycle N; core_start at N+1.
  - core_done at cycle D ≥ N+2 gives rsp_valid at D+1.
  - Response handshake at R gives the next req ready at R+1, for a minimum 4-cycle turnaround beyond core latency.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,… No requester waits more than one foreign transaction.
- Arithmetic: data is passed through unmodified; no sign extension or rounding.
- busy = (state != IDLE).

Optional Feature:
- Macro CORDIC_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYC without core_done: go to RESP with rsp_sin=0, rsp_cos=0, rsp_err=1.
  - A core_done that arrives after the abort is ignored.
  - core_done on the same cycle the counter expires wins: normal result, rsp_err=0.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req0_valid=1 → all outputs 0, req0_ready=0. After release, req0_ready=1 on the first IDLE cycle.
- Single request: req0 beta=17'h0C910 with a core model of done 9 cycles after start, returning sin=17'h05A82, cos=17'h05A82.
  - core_start exactly 1 cycle after handshake.
  - rsp_valid 1 cycle after done with id=0, sin=cos=17'h05A82, err=0.
- Contention: both requesters valid continuously for 6 transactions → grant order 0,1,0,1,0,1. Each response id matches its own beta echoed by the core model.
- Response backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid → rsp fields stable, req*_ready=0, and a stray core_done pulse during RESP changes nothing.
- Mid-operation reset: assert rst_n=0 in WAIT, then fire core_done after release → no rsp_valid, state IDLE, last_grant=1.
- Timeout (macro defined, TIMEOUT_CYC=32): core never asserts done → rsp_valid 32 cycles into WAIT with err=1, sin=cos=0. A late done is ignored, and the next request completes normally.
